vga_rx_timing_recovery: RTL

- Receive-side counterpart to the team's 640x480p60 VGA timing driver.
- Samples negative-polarity hsync/vsync plus 2-bit-per-channel RGB in the clk_pix domain.
- Regenerates pixel coordinates and data enable, measures line/frame periods, and declares lock once timing matches the configured mode.
- Used as a loopback checker and capture front-end in simulation and on-chip self-test.

---
 rtl/vga_rx_timing_recovery.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vga_rx_timing_recovery.sv
// rtl/vga_rx_timing_recovery.sv - recovers VGA pixel timing from sampled sync/RGB
module vga_rx_timing_recovery #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int HS_STA      = 655,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int VS_STA      = 489,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_pix,
    input  logic        rst_pix,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [1:0]  r_in,
    input  logic [1:0]  g_in,
    input  logic [1:0]  b_in,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        rx_de,
    output logic [1:0]  rx_r,
    output logic [1:0]  rx_g,
    output logic [1:0]  rx_b,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [10:0] line_len,
    output logic [9:0]  frame_len
);

    localparam int LC_W = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [LC_W-1:0] LOCK_MAX = LC_W'(LOCK_FRAMES);

    logic            hsync_q, vsync_q, hsync_d, vsync_d;
    logic [5:0]      rgb_q;
    logic [9:0]      x_q, y_q;
    logic            h_seen, v_seen, err_flag;
    logic [LC_W-1:0] lock_cnt;
    logic [10:0]     clk_cnt;
    logic [9:0]      line_cnt;

    logic            hfall, vfall, x_wrap, h_mis, v_mis, wd_fire, mismatch;
    logic [9:0]      x_pred, y_pred, x_s, y_s;
    logic [LC_W-1:0] lock_cnt_nxt;
    logic            locked_nxt, err_flag_nxt;

    // x_pred/y_pred: where the free-running counters place the current sample
    always_comb begin
        hfall    = !hsync_q && hsync_d;
        vfall    = !vsync_q && vsync_d;
        x_wrap   = (x_q == 10'(H_TOTAL - 1));
        x_pred   = x_wrap ? 10'd0 : x_q + 10'd1;
        y_pred   = y_q;
        if (x_wrap)
            y_pred = (y_q == 10'(V_TOTAL - 1)) ? 10'd0 : y_q + 10'd1;
        h_mis    = hfall && h_seen && (x_pred != 10'(HS_STA));
        v_mis    = vfall && v_seen && ((x_pred != 10'd0) || (y_pred != 10'(VS_STA)));
        wd_fire  = !hfall && (clk_cnt == 11'(2 * H_TOTAL));
        mismatch = h_mis || v_mis || wd_fire;
        // vfall reload takes priority over the hfall reload
        x_s      = vfall ? 10'd0 : (hfall ? 10'(HS_STA) : x_pred);
        y_s      = vfall ? 10'(VS_STA) : y_pred;
    end

    always_comb begin
        lock_cnt_nxt = lock_cnt;
        locked_nxt   = locked;
        err_flag_nxt = err_flag;
        if (mismatch) begin
            lock_cnt_nxt = '0;
            locked_nxt   = 1'b0;
            err_flag_nxt = 1'b1;
        end else if (vfall && v_seen && !err_flag) begin
            if (lock_cnt != LOCK_MAX)
                lock_cnt_nxt = lock_cnt + 1'b1;
            if (lock_cnt_nxt == LOCK_MAX)
                locked_nxt = 1'b1;
        end
        // every frame boundary opens a fresh error window
        if (vfall)
            err_flag_nxt = 1'b0;
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            hsync_d     <= 1'b1;
            vsync_d     <= 1'b1;
            rgb_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            h_seen      <= 1'b0;
            v_seen      <= 1'b0;
            err_flag    <= 1'b0;
            lock_cnt    <= '0;
            clk_cnt     <= '0;
            line_cnt    <= '0;
            rx_x        <= '0;
            rx_y        <= '0;
            rx_de       <= 1'b0;
            rx_r        <= '0;
            rx_g        <= '0;
            rx_b        <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            line_len    <= '0;
            frame_len   <= '0;
        end else begin
            hsync_q  <= hsync_in;
            vsync_q  <= vsync_in;
            rgb_q    <= {r_in, g_in, b_in};
            hsync_d  <= hsync_q;
            vsync_d  <= vsync_q;
            x_q      <= x_s;
            y_q      <= y_s;

            if (hfall)
                h_seen <= 1'b1;
            else if (wd_fire)
                h_seen <= 1'b0;
            if (vfall)
                v_seen <= 1'b1;

            if (hfall) begin
                if (h_seen)
                    line_len <= clk_cnt;
                clk_cnt <= 11'd1;
            end else if (clk_cnt != 11'h7FF) begin
                clk_cnt <= clk_cnt + 11'd1;
            end

            if (vfall) begin
                if (v_seen)
                    frame_len <= line_cnt;
                line_cnt <= {9'd0, hfall};
            end else if (hfall && (line_cnt != 10'h3FF)) begin
                line_cnt <= line_cnt + 10'd1;
            end

            err_flag    <= err_flag_nxt;
            lock_cnt    <= lock_cnt_nxt;
            locked      <= locked_nxt;
            sync_err    <= mismatch;
            rx_x        <= x_s;
            rx_y        <= y_s;
            rx_de       <= locked_nxt && (x_s < 10'(H_ACTIVE)) && (y_s < 10'(V_ACTIVE));
            frame_start <= locked_nxt && (x_s == 10'd0) && (y_s == 10'd0);
            rx_r        <= rgb_q[5:4];
            rx_g        <= rgb_q[3:2];
            rx_b        <= rgb_q[1:0];
        end
    end

endmodule
